// File: rtl/btn_debounce_pulse_pkg.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse_pkg
// Shared definitions for the push-button conditioning block:
//   - btn_state_t     : debounce FSM state encodings
//   - DEFAULT_*       : cycle counts for the 100 MHz board clock
//   - max_int()       : helper used to size the shared repeat counter
// -----------------------------------------------------------------------------
package btn_debounce_pulse_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // 10 ms debounce, 500 ms to the first repeat, then one repeat per 200 ms.
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int DEFAULT_REPEAT_DELAY    = 50000000;
   localparam int DEFAULT_REPEAT_RATE     = 20000000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse_if
// Button pin in, conditioned level and strobes out.
//   i_Btn               : raw asynchronous button pin (1 = pressed)
//   o_Btn_Level         : debounced button state
//   o_Btn_Pulse         : one-cycle strobe on press and on each auto-repeat
//   o_Btn_Release_Pulse : one-cycle strobe on release
// master = the side driving the pin and consuming the strobes,
// slave  = the conditioning block itself.
// -----------------------------------------------------------------------------
interface btn_debounce_pulse_if;

   logic i_Btn;
   logic o_Btn_Level;
   logic o_Btn_Pulse;
   logic o_Btn_Release_Pulse;

   modport master (
      output i_Btn,
      input  o_Btn_Level,
      input  o_Btn_Pulse,
      input  o_Btn_Release_Pulse
   );

   modport slave (
      input  i_Btn,
      output o_Btn_Level,
      output o_Btn_Pulse,
      output o_Btn_Release_Pulse
   );

endinterface

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Parameterised-width two-flop synchroniser for asynchronous inputs.
//   clk  : destination clock
//   srst : synchronous active-high reset, clears both stages
//   d    : asynchronous input bits
//   q    : synchronised output (second stage)
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         always_ff @(posedge clk) begin
            if (srst) begin
               sync1_reg[gi] <= 1'b0;
               sync2_reg[gi] <= 1'b0;
            end else begin
               sync1_reg[gi] <= d[gi];
               sync2_reg[gi] <= sync1_reg[gi];
            end
         end
      end
   endgenerate

   assign q = sync2_reg;

endmodule

// File: rtl/btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse
// Turns one raw push-button pin into a debounced level, a one-cycle press
// strobe (optionally auto-repeating while held) and a one-cycle release strobe.
//   i_Clk   : system clock, all logic on its rising edge
//   i_Reset : synchronous active-high reset
//   bus     : slave side of btn_debounce_pulse_if (pin in, level/strobes out)
// -----------------------------------------------------------------------------
module btn_debounce_pulse
   import btn_debounce_pulse_pkg::*;
#(
   parameter int g_DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int g_REPEAT_EN       = 0,
   parameter int g_REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int g_REPEAT_RATE     = DEFAULT_REPEAT_RATE
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   btn_debounce_pulse_if.slave   bus
);

   localparam int DB_W    = $clog2(g_DEBOUNCE_CYCLES);
   localparam int REP_MAX = max_int(g_REPEAT_DELAY, g_REPEAT_RATE);
   localparam int REP_W   = $clog2(REP_MAX);
   localparam bit REP_EN  = (g_REPEAT_EN != 0);

   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(g_DEBOUNCE_CYCLES - 1);
   localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(g_REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(g_REPEAT_RATE - 1);

   logic btn_s;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk  (i_Clk),
      .srst (i_Reset),
      .d    (bus.i_Btn),
      .q    (btn_s)
   );

   btn_state_t       state_reg,   state_next;
   logic [DB_W-1:0]  db_cnt_reg,  db_cnt_next;
   logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
   logic             first_reg,   first_next;
   logic             level_reg,   level_next;
   logic             pulse_reg,   pulse_next;
   logic             rel_reg,     rel_next;
   logic [REP_W-1:0] rep_last;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_reg   <= IDLE;
         db_cnt_reg  <= '0;
         rep_cnt_reg <= '0;
         first_reg   <= 1'b0;
         level_reg   <= 1'b0;
         pulse_reg   <= 1'b0;
         rel_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         db_cnt_reg  <= db_cnt_next;
         rep_cnt_reg <= rep_cnt_next;
         first_reg   <= first_next;
         level_reg   <= level_next;
         pulse_reg   <= pulse_next;
         rel_reg     <= rel_next;
      end
   end

   // First repeat waits the long delay, later ones use the shorter rate.
   assign rep_last = first_reg ? DELAY_LAST : RATE_LAST;

   always_comb begin
      state_next   = state_reg;
      db_cnt_next  = db_cnt_reg;
      rep_cnt_next = rep_cnt_reg;
      first_next   = first_reg;
      level_next   = level_reg;
      pulse_next   = 1'b0;
      rel_next     = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (btn_s) begin
               state_next  = PRESS_WAIT;
               db_cnt_next = '0;
            end
         end

         PRESS_WAIT: begin
            if (!btn_s) begin
               state_next = IDLE;
            end else if (db_cnt_reg == DB_LAST) begin
               state_next   = PRESSED;
               level_next   = 1'b1;
               pulse_next   = 1'b1;
               rep_cnt_next = '0;
               first_next   = 1'b1;
            end else begin
               db_cnt_next = db_cnt_reg + 1'b1;
            end
         end

         PRESSED: begin
            if (!btn_s) begin
               state_next  = RELEASE_WAIT;
               db_cnt_next = '0;
            end else if (REP_EN) begin
               if (rep_cnt_reg == rep_last) begin
                  pulse_next   = 1'b1;
                  rep_cnt_next = '0;
                  first_next   = 1'b0;
               end else begin
                  rep_cnt_next = rep_cnt_reg + 1'b1;
               end
            end
         end

         RELEASE_WAIT: begin
            // The repeat counter is left untouched here so that a release
            // bounce resumes the repeat timing rather than restarting it.
            if (btn_s) begin
               state_next = PRESSED;
            end else if (db_cnt_reg == DB_LAST) begin
               state_next = IDLE;
               level_next = 1'b0;
               rel_next   = 1'b1;
            end else begin
               db_cnt_next = db_cnt_reg + 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign bus.o_Btn_Level         = level_reg;
   assign bus.o_Btn_Pulse         = pulse_reg;
   assign bus.o_Btn_Release_Pulse = rel_reg;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_pulse
// Two instances share one pin stimulus: dut_a (no repeat) and dut_b
// (repeat, delay 10, rate 3); both debounce over 4 cycles.
// -----------------------------------------------------------------------------
module tb_btn_debounce_pulse;

   localparam int DB    = 4;
   localparam int DLY_B = 10;
   localparam int RATE_B = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   btn_debounce_pulse_if bus_a ();
   btn_debounce_pulse_if bus_b ();

   btn_debounce_pulse #(
      .g_DEBOUNCE_CYCLES (DB),
      .g_REPEAT_EN       (0)
   ) dut_a (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus_a)
   );

   btn_debounce_pulse #(
      .g_DEBOUNCE_CYCLES (DB),
      .g_REPEAT_EN       (1),
      .g_REPEAT_DELAY    (DLY_B),
      .g_REPEAT_RATE     (RATE_B)
   ) dut_b (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus_b)
   );

   typedef struct {
      logic lvl;
      logic pulse;
      logic rel;
   } exp_t;

   typedef struct {
      logic rst;
      logic btn;
      exp_t exp;
   } vec_t;

   // Behavioural reference: a press is accepted once the synchronised pin
   // has read the opposite of the current level for DB+1 consecutive edges.
   typedef struct {
      bit s1;
      bit s2;
      bit lvl;
      bit first;
      bit pulse;
      bit rel;
      int run;
      int rep;
   } model_t;

   int     n_applied     = 0;
   int     n_miscompares = 0;
   int     pulses_a      = 0;
   int     pulses_b      = 0;
   model_t ma;
   model_t mb;
   exp_t   q_a[$];
   exp_t   q_b[$];
   vec_t   vecs[$];

   function automatic model_t model_step(input model_t m, input logic btn, input logic r,
                                         input bit rep_en, input int dly, input int rate);
      model_t n;
      bit     s;
      bit     was_pressed;
      n = m;
      n.pulse = 1'b0;
      n.rel   = 1'b0;
      if (r) begin
         n = '{default: 0};
         return n;
      end
      s    = m.s2;
      n.s2 = m.s1;
      n.s1 = btn;
      if (!m.lvl) begin
         n.run = s ? m.run + 1 : 0;
         if (n.run == DB + 1) begin
            n.lvl = 1'b1; n.pulse = 1'b1; n.run = 0; n.rep = 0; n.first = 1'b1;
         end
      end else begin
         was_pressed = (m.run == 0);
         n.run = !s ? m.run + 1 : 0;
         if (n.run == DB + 1) begin
            n.lvl = 1'b0; n.rel = 1'b1; n.run = 0;
         end else if (s && was_pressed && rep_en) begin
            if (m.rep == (m.first ? dly : rate) - 1) begin
               n.pulse = 1'b1; n.rep = 0; n.first = 1'b0;
            end else begin
               n.rep = m.rep + 1;
            end
         end
      end
      return n;
   endfunction

   task automatic compare(input string tag, input string who, input exp_t e,
                          input logic l, input logic p, input logic r);
      n_applied++;
      if (l !== e.lvl || p !== e.pulse || r !== e.rel) begin
         n_miscompares++;
         $display("FAIL %s/%s t=%0t: got lvl=%b pulse=%b rel=%b, want lvl=%b pulse=%b rel=%b",
                  tag, who, $time, l, p, r, e.lvl, e.pulse, e.rel);
      end
   endtask

   // One clock: drive, push expectations, wait past the edge, pop and compare.
   // With use_vec set, dut_a is judged against the table entry instead of the model.
   task automatic drive(input logic btn, input logic r, input string tag,
                        input bit use_vec, input exp_t vexp);
      exp_t ea;
      exp_t eb;
      bus_a.i_Btn = btn;
      bus_b.i_Btn = btn;
      rst = r;
      ma = model_step(ma, btn, r, 1'b0, 0, 0);
      mb = model_step(mb, btn, r, 1'b1, DLY_B, RATE_B);
      q_a.push_back(use_vec ? vexp : exp_t'{ma.lvl, ma.pulse, ma.rel});
      q_b.push_back(exp_t'{mb.lvl, mb.pulse, mb.rel});
      @(posedge clk);
      #1;
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      compare(tag, "A", ea, bus_a.o_Btn_Level, bus_a.o_Btn_Pulse, bus_a.o_Btn_Release_Pulse);
      compare(tag, "B", eb, bus_b.o_Btn_Level, bus_b.o_Btn_Pulse, bus_b.o_Btn_Release_Pulse);
      if (bus_a.o_Btn_Pulse === 1'b1) pulses_a++;
      if (bus_b.o_Btn_Pulse === 1'b1) pulses_b++;
      $display("[%0t] %s btn=%b rst=%b | A %b%b%b B %b%b%b", $time, tag, btn, r,
               bus_a.o_Btn_Level, bus_a.o_Btn_Pulse, bus_a.o_Btn_Release_Pulse,
               bus_b.o_Btn_Level, bus_b.o_Btn_Pulse, bus_b.o_Btn_Release_Pulse);
   endtask

   task automatic hold(input logic btn, input int n, input string tag);
      for (int i = 0; i < n; i++) drive(btn, 1'b0, tag, 1'b0, exp_t'{0, 0, 0});
   endtask

   task automatic add_vecs(input logic r, input logic btn, input int n,
                           input logic l, input logic p, input logic rl);
      for (int i = 0; i < n; i++) vecs.push_back(vec_t'{r, btn, exp_t'{l, p, rl}});
   endtask

   task automatic check_count(input string tag, input int got, input int want);
      n_applied++;
      if (got != want) begin
         n_miscompares++;
         $display("FAIL %s: got %0d pulses, want %0d", tag, got, want);
      end
   endtask

   initial begin
      ma = '{default: 0};
      mb = '{default: 0};
      bus_a.i_Btn = 1'b0;
      bus_b.i_Btn = 1'b0;

      // Clean press then release on dut_a, with hand-derived timing:
      // pin high before edge 10 -> pulse after edge 16; pin low before
      // edge 21 -> release pulse after edge 27.
      add_vecs(1, 0, 2, 0, 0, 0);   // 0..1   reset
      add_vecs(0, 0, 8, 0, 0, 0);   // 2..9   idle
      add_vecs(0, 1, 6, 0, 0, 0);   // 10..15 qualifying
      add_vecs(0, 1, 1, 1, 1, 0);   // 16     press pulse
      add_vecs(0, 1, 4, 1, 0, 0);   // 17..20 held
      add_vecs(0, 0, 6, 1, 0, 0);   // 21..26 release qualifying
      add_vecs(0, 0, 1, 0, 0, 1);   // 27     release pulse
      add_vecs(0, 0, 3, 0, 0, 0);   // 28..30 idle

      foreach (vecs[i]) drive(vecs[i].btn, vecs[i].rst, "vec", 1'b1, vecs[i].exp);

      // Press bounce: 1,0,1,0,1 then held.
      pulses_a = 0; pulses_b = 0;
      hold(1, 1, "bounce"); hold(0, 1, "bounce"); hold(1, 1, "bounce");
      hold(0, 1, "bounce"); hold(1, 14, "bounce"); hold(0, 14, "bounce_rel");
      check_count("bounce_pulses_A", pulses_a, 1);

      // Release glitch of 2 cycles must not release.
      hold(1, 12, "rglitch"); hold(0, 2, "rglitch"); hold(1, 8, "rglitch");
      hold(0, 12, "rglitch_rel");

      // Auto-repeat: 40-cycle hold gives press + 9 repeats on dut_b.
      pulses_a = 0; pulses_b = 0;
      hold(1, 40, "repeat"); hold(0, 14, "repeat_rel");
      check_count("repeat_pulses_A", pulses_a, 1);
      check_count("repeat_pulses_B", pulses_b, 10);

      // Reset during PRESS_WAIT with pin held, then fresh press.
      hold(1, 5, "rst_pw");
      drive(1, 1'b1, "rst_pw_assert", 1'b0, exp_t'{0, 0, 0});
      pulses_a = 0;
      hold(1, 12, "rst_pw_after");
      check_count("rst_pw_fresh_A", pulses_a, 1);

      // Reset while PRESSED, pin held through it.
      drive(1, 1'b1, "rst_pr_assert", 1'b0, exp_t'{0, 0, 0});
      hold(1, 12, "rst_pr_after");
      hold(0, 14, "rst_pr_rel");

      // Random bouncy activity.
      for (int k = 0; k < 60; k++) begin
         hold(logic'($urandom_range(0, 1)), int'($urandom_range(1, 8)), "rand");
      end
      hold(0, 14, "final");

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
      $finish;
   end

endmodule
